// File: rtl/gfx_pkg.sv
// Shared types and constants for the 8x8 rasterizer command front end.
package gfx_pkg;

    localparam int CMD_W       = 2;
    localparam int COORD_W     = 3;
    localparam int PIXELS      = 64;
    // Source id field sized for the largest supported requester count (4).
    localparam int ENTRY_SRC_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_FS = 2'd2,
        STREAM  = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [ENTRY_SRC_W-1:0] src;
        logic [CMD_W-1:0]       cmd;
        logic [COORD_W-1:0]     x;
        logic [COORD_W-1:0]     y;
    } cmd_entry_t;

endpackage

// File: rtl/gfx_cmd_scheduler_if.sv
// Requester-side and processor-side handshake bundle of the command scheduler.
interface gfx_cmd_scheduler_if #(
    parameter int NREQ = 2
);
    import gfx_pkg::*;

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [CMD_W*NREQ-1:0]   req_cmd;
    logic [COORD_W*NREQ-1:0] req_x;
    logic [COORD_W*NREQ-1:0] req_y;

    logic [CMD_W-1:0]        gp_command;
    logic [COORD_W-1:0]      gp_x1;
    logic [COORD_W-1:0]      gp_y1;
    logic                    gp_command_valid;
    logic                    gp_frame_start;

    modport master (
        output req_valid, req_cmd, req_x, req_y, gp_frame_start,
        input  req_ready, gp_command, gp_x1, gp_y1, gp_command_valid
    );

    modport slave (
        input  req_valid, req_cmd, req_x, req_y, gp_frame_start,
        output req_ready, gp_command, gp_x1, gp_y1, gp_command_valid
    );

endinterface

// File: rtl/gfx_cmd_fifo.sv
// Synchronous FIFO with occupancy count; push into a full or pop from an empty FIFO is ignored.
module gfx_cmd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 10,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/gfx_cmd_scheduler.sv
// Round-robin command arbiter, command FIFO and issue/frame tracking FSM in front of
// the 8x8 rasterizer; a watchdog flags a processor that never answers with frame_start.
module gfx_cmd_scheduler
    import gfx_pkg::*;
#(
    parameter  int NREQ       = 2,
    parameter  int FIFO_DEPTH = 4,
    parameter  int PIXELS     = gfx_pkg::PIXELS,
    parameter  int TIMEOUT    = 15,
    localparam int SRC_W      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
    localparam int PIX_W      = $clog2(PIXELS),
    localparam int WD_W       = $clog2(TIMEOUT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    gfx_cmd_scheduler_if.slave        bus,
    input  logic                      clear_err,
    output logic                      busy,
    output logic [CNT_W-1:0]          fifo_count,
    output logic [SRC_W-1:0]          active_src,
    output logic                      timeout_err
);

    logic             fifo_full, fifo_empty, push, pop;
    cmd_entry_t       push_entry, head;
    logic [NREQ-1:0]  ready;
    logic [SRC_W-1:0] winner;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    sched_state_t       state_q, state_d;
    logic [CMD_W-1:0]   gp_command_q, gp_command_d;
    logic [COORD_W-1:0] gp_x1_q, gp_x1_d;
    logic [COORD_W-1:0] gp_y1_q, gp_y1_d;
    logic               gp_valid_q, gp_valid_d;
    logic [SRC_W-1:0]   active_src_q, active_src_d;
    logic [PIX_W-1:0]   cnt_q, cnt_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               timeout_err_q, timeout_err_d;

    // Registered count gates acceptance, so a same-cycle pop never frees a slot early.
    always_comb begin
        ready  = '0;
        push   = 1'b0;
        winner = '0;
        if (!fifo_full) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!push && bus.req_valid[(int'(rr_ptr_q) + i) % NREQ]) begin
                    push   = 1'b1;
                    winner = SRC_W'((int'(rr_ptr_q) + i) % NREQ);
                end
            end
        end
        ready[winner] = push;
        rr_ptr_d      = push ? SRC_W'((int'(winner) + 1) % NREQ) : rr_ptr_q;
    end

    always_comb begin
        push_entry.src = ENTRY_SRC_W'(winner);
        push_entry.cmd = bus.req_cmd[CMD_W*int'(winner) +: CMD_W];
        push_entry.x   = bus.req_x[COORD_W*int'(winner) +: COORD_W];
        push_entry.y   = bus.req_y[COORD_W*int'(winner) +: COORD_W];
    end

    gfx_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(cmd_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (push_entry),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        gp_command_d  = gp_command_q;
        gp_x1_d       = gp_x1_q;
        gp_y1_d       = gp_y1_q;
        gp_valid_d    = 1'b0;
        active_src_d  = active_src_q;
        cnt_d         = cnt_q;
        wdog_d        = wdog_q;
        pop           = 1'b0;
        // A watchdog set later in this cycle overrides the clear.
        timeout_err_d = timeout_err_q && !clear_err;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    gp_command_d = head.cmd;
                    gp_x1_d      = head.x;
                    gp_y1_d      = head.y;
                    active_src_d = head.src[SRC_W-1:0];
                    gp_valid_d   = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT_FS;
            end
            WAIT_FS: begin
                if (bus.gp_frame_start) begin
                    cnt_d   = PIX_W'(PIXELS - 1);
                    state_d = STREAM;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            STREAM: begin
                // The frame_start cycle carries the first pixel, so leave once the count expires.
                cnt_d = cnt_q - PIX_W'(1);
                if (cnt_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            gp_command_q  <= '0;
            gp_x1_q       <= '0;
            gp_y1_q       <= '0;
            gp_valid_q    <= 1'b0;
            active_src_q  <= '0;
            cnt_q         <= '0;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gp_command_q  <= gp_command_d;
            gp_x1_q       <= gp_x1_d;
            gp_y1_q       <= gp_y1_d;
            gp_valid_q    <= gp_valid_d;
            active_src_q  <= active_src_d;
            cnt_q         <= cnt_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.req_ready        = ready;
    assign bus.gp_command       = gp_command_q;
    assign bus.gp_x1            = gp_x1_q;
    assign bus.gp_y1            = gp_y1_q;
    assign bus.gp_command_valid = gp_valid_q;
    assign active_src           = active_src_q;
    assign timeout_err          = timeout_err_q;
    assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_gfx_cmd_scheduler.sv
// Directed bench for gfx_cmd_scheduler with a processor model answering frame_start two cycles after each issue.
module tb_gfx_cmd_scheduler;
    import gfx_pkg::*;

    localparam int NREQ       = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear_err = 1'b0;
    logic       busy;
    logic [2:0] fifo_count;
    logic [0:0] active_src;
    logic       timeout_err;
    logic       fs_auto = 1'b0;
    logic       fs_manual = 1'b0;
    logic       model_en = 1'b0;
    int         fs_delay = 0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         iss_cyc[$];
    int         iss_src[$];
    int         iss_x[$];

    gfx_cmd_scheduler_if #(.NREQ(NREQ)) bus ();
    assign bus.gp_frame_start = fs_auto | fs_manual;

    gfx_cmd_scheduler #(
        .NREQ       (NREQ),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PIXELS     (64),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .clear_err   (clear_err),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .active_src  (active_src),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Processor model: frame_start high during the second cycle after the issue strobe.
    always @(negedge clk) begin
        if (!rst_n) begin
            fs_delay <= 0;
            fs_auto  <= 1'b0;
        end else begin
            fs_auto <= (fs_delay == 1);
            if (model_en && bus.gp_command_valid) fs_delay <= 2;
            else if (fs_delay > 0)                fs_delay <= fs_delay - 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.gp_command_valid) begin
            iss_cyc.push_back(cyc);
            iss_src.push_back(int'(active_src));
            iss_x.push_back(int'(bus.gp_x1));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        iss_cyc.delete();
        iss_src.delete();
        iss_x.delete();
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while ((busy !== 1'b0 || fifo_count !== 3'd0) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic check_spacing(input string tag, input int n);
        check({tag, "_count"}, iss_cyc.size(), n);
        for (int k = 1; k < iss_cyc.size(); k++)
            check(tag, iss_cyc[k] - iss_cyc[k-1], 67);
    endtask

    initial begin
        logic [1:0] exp_ready [4];
        int         exp_src   [4];
        int         exp_x     [4];
        int         n;

        exp_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_src   = '{0, 1, 0, 1};
        exp_x     = '{1, 6, 1, 6};

        bus.req_valid = '0;
        bus.req_cmd   = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_src", active_src, 0);
        check("rst_err", timeout_err, 0);
        check("rst_valid", bus.gp_command_valid, 0);
        check("rst_cmd", bus.gp_command, 0);
        check("rst_x", bus.gp_x1, 0);
        check("rst_ready", bus.req_ready, 0);
        rst_n    = 1'b1;
        model_en = 1'b1;
        tick();

        // Single request from requester 0
        bus.req_valid    = 2'b01;
        bus.req_cmd[1:0] = 2'd1;
        bus.req_x[2:0]   = 3'd3;
        bus.req_y[2:0]   = 3'd5;
        #1;
        check("t1_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = '0;
        check("t1_count", fifo_count, 1);
        check("t1_early_valid", bus.gp_command_valid, 0);
        tick();
        check("t1_valid", bus.gp_command_valid, 1);
        check("t1_cmd", bus.gp_command, 1);
        check("t1_x", bus.gp_x1, 3);
        check("t1_y", bus.gp_y1, 5);
        check("t1_src", active_src, 0);
        check("t1_count_pop", fifo_count, 0);
        repeat (65) tick();
        check("t1_busy_last", busy, 1);
        check("t1_x_hold", bus.gp_x1, 3);
        check("t1_valid_low", bus.gp_command_valid, 0);
        tick();
        check("t1_idle", busy, 0);
        check("t1_issues", iss_cyc.size(), 1);

        // Spurious frame_start in IDLE, then during STREAM (requester 1)
        fs_manual = 1'b1;
        tick();
        fs_manual = 1'b0;
        check("t6_idle_fs_busy", busy, 0);
        tick();
        check("t6_idle_fs_valid", bus.gp_command_valid, 0);
        bus.req_valid    = 2'b10;
        bus.req_cmd[3:2] = 2'd2;
        bus.req_x[5:3]   = 3'd6;
        bus.req_y[5:3]   = 3'd1;
        #1;
        check("t6_ready", bus.req_ready, 2'b10);
        tick();
        bus.req_valid = '0;
        tick();
        check("t6_valid", bus.gp_command_valid, 1);
        check("t6_src", active_src, 1);
        check("t6_x", bus.gp_x1, 6);
        repeat (20) tick();
        fs_manual = 1'b1;
        tick();
        fs_manual = 1'b0;
        repeat (44) tick();
        check("t6_busy_last", busy, 1);
        tick();
        check("t6_no_reload", busy, 0);

        // Round-robin with both requesters valid
        clear_log();
        bus.req_valid    = 2'b11;
        bus.req_cmd      = {2'd3, 2'd2};
        bus.req_x        = {3'd6, 3'd1};
        bus.req_y        = {3'd7, 3'd2};
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_grant", bus.req_ready, exp_ready[k]);
            tick();
        end
        bus.req_valid = '0;
        check("t2_count", fifo_count, 3);
        drain(400, "t2_drain");
        check_spacing("t2_period", 4);
        for (int k = 0; k < iss_src.size() && k < 4; k++) begin
            check("t2_src", iss_src[k], exp_src[k]);
            check("t2_x", iss_x[k], exp_x[k]);
        end

        // Backpressure: six requests from requester 0
        clear_log();
        bus.req_valid = 2'b01;
        for (int i = 0; i < 6; i++) begin
            bus.req_cmd[1:0] = 2'(i);
            bus.req_x[2:0]   = 3'(i);
            bus.req_y[2:0]   = 3'(7 - i);
            #1;
            if (i == 5) begin
                check("t3_full_count", fifo_count, 4);
                check("t3_full_ready", bus.req_ready, 2'b00);
            end
            n = 0;
            while (bus.req_ready[0] !== 1'b1 && n < 200) begin
                tick();
                #1;
                n++;
            end
            check("t3_accept", 32'(n < 200), 32'd1);
            if (i == 5) check("t3_no_bypass", fifo_count, 3);
            tick();
        end
        bus.req_valid = '0;
        drain(600, "t3_drain");
        check_spacing("t3_period", 6);
        for (int k = 0; k < iss_x.size() && k < 6; k++)
            check("t3_order", iss_x[k], k);

        // Watchdog: processor never answers
        clear_log();
        model_en         = 1'b0;
        bus.req_valid    = 2'b10;
        bus.req_cmd[3:2] = 2'd1;
        bus.req_x[5:3]   = 3'd4;
        bus.req_y[5:3]   = 3'd0;
        tick();
        bus.req_x[5:3]   = 3'd5;
        tick();
        bus.req_valid = '0;
        check("t4_valid1", bus.gp_command_valid, 1);
        check("t4_x1", bus.gp_x1, 4);
        repeat (15) tick();
        check("t4_err_before", timeout_err, 0);
        check("t4_busy_before", busy, 1);
        tick();
        check("t4_err_set", timeout_err, 1);
        check("t4_idle", busy, 0);
        tick();
        check("t4_valid2", bus.gp_command_valid, 1);
        check("t4_x2", bus.gp_x1, 5);
        check("t4_sticky", timeout_err, 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("t4_cleared", timeout_err, 0);
        repeat (14) tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("t4_set_wins", timeout_err, 1);
        check("t4_idle2", busy, 0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("t4_cleared2", timeout_err, 0);
        check("t4_issues", iss_cyc.size(), 2);

        // Reset mid-stream with two entries queued
        model_en         = 1'b1;
        bus.req_valid    = 2'b01;
        bus.req_cmd[1:0] = 2'd3;
        bus.req_x[2:0]   = 3'd2;
        bus.req_y[2:0]   = 3'd4;
        tick();
        tick();
        check("t5_valid", bus.gp_command_valid, 1);
        tick();
        bus.req_valid = '0;
        repeat (35) tick();
        check("t5_queued", fifo_count, 2);
        check("t5_streaming", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_count", fifo_count, 0);
        check("t5_cmd", bus.gp_command, 0);
        check("t5_x", bus.gp_x1, 0);
        check("t5_y", bus.gp_y1, 0);
        check("t5_valid_rst", bus.gp_command_valid, 0);
        clear_log();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (100) tick();
        check("t5_no_issue", iss_cyc.size(), 0);
        check("t5_empty", fifo_count, 0);
        check("t5_idle", busy, 0);
        bus.req_valid  = 2'b01;
        bus.req_x[2:0] = 3'd7;
        tick();
        bus.req_valid = '0;
        tick();
        check("t5_new_valid", bus.gp_command_valid, 1);
        check("t5_new_x", bus.gp_x1, 7);
        drain(100, "t5_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
